// File: rtl/sprite_rotation_sequencer.sv
// Sprite rotation sequencer: once per frame, snapshots the ant heading, starts
// the CORDIC rotator and captures its 57 rotated rows into a back bank. A
// completed capture swaps the back bank to the front, where the overlay reads it.
//
// CORDIC handshake: CordicRST is a one-cycle start pulse. CordicDONE is a
// level; while it is high, CordicDATA is valid every cycle, one row per cycle,
// with two pipeline-fill beats first. If CordicDONE drops before the last row,
// the partial capture is abandoned and the front bank is left untouched.
module sprite_rotation_sequencer (
  input  logic        logicCLK,
  input  logic        RSTn,
  input  logic        frameStart,
  input  logic        TLeft,
  input  logic        TRight,
  input  logic        win,
  output logic        CordicRST,
  output logic [9:0]  CordicIDX,
  input  logic        CordicDONE,
  input  logic [56:0] CordicDATA,
  output logic [12:0] angleOut,
  input  logic [5:0]  rowAddr,
  output logic [56:0] rowData,
  output logic        bankSel,
  output logic        busy,
  output logic        overrun,
  input  logic        angleLoad,
  input  logic [21:0] angleLoadVal,
  output logic [21:0] angleDbg,
  output logic [2:0]  stateDbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    SWAP    = 3'd4
  } state_t;

  localparam logic [21:0] PI     = 22'h192000;
  localparam logic [21:0] NEG_PI = 22'h26E000;
  localparam logic [9:0]  LAST_IDX = 10'd58;

  state_t      state;
  state_t      stateNext;
  logic [9:0]  idxNext;
  logic        latchAngle;
  logic        wrEn;
  logic        toggleBank;
  logic [5:0]  wrRow;
  logic [21:0] angle;
  logic [21:0] angleNext;
  logic [56:0] bank [2][57];

  // The first two beats are pipeline fill, so row N arrives at index N+2.
  assign wrRow    = CordicIDX[5:0] - 6'd2;
  assign busy     = (state != IDLE);
  assign angleDbg = angle;
  assign stateDbg = state;

  // FSM next state and per-state controls.
  always_comb begin
    stateNext  = state;
    idxNext    = CordicIDX;
    CordicRST  = 1'b0;
    latchAngle = 1'b0;
    wrEn       = 1'b0;
    toggleBank = 1'b0;
    case (state)
      IDLE: begin
        idxNext = '0;
        if (frameStart) begin
          latchAngle = 1'b1;
          stateNext  = START;
        end
      end
      START: begin
        CordicRST = 1'b1;
        idxNext   = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        idxNext = '0;
        if (CordicDONE) stateNext = CAPTURE;
      end
      CAPTURE: begin
        if (CordicDONE) begin
          idxNext = CordicIDX + 10'd1;
          if (CordicIDX >= 10'd2) wrEn = 1'b1;
          if (CordicIDX == LAST_IDX) stateNext = SWAP;
        end else begin
          idxNext   = '0;
          stateNext = IDLE;
        end
      end
      SWAP: begin
        toggleBank = 1'b1;
        idxNext    = '0;
        stateNext  = IDLE;
      end
      default: begin
        idxNext   = '0;
        stateNext = IDLE;
      end
    endcase
  end

  // Heading: wraps at +/-PI, steers unless won, frozen while rows are captured.
  always_comb begin
    angleNext = angle;
    if (angleLoad) begin
      angleNext = angleLoadVal;
    end else if (state != CAPTURE) begin
      if (angle == PI)                angleNext = NEG_PI + 22'd1;
      else if (angle == NEG_PI)       angleNext = PI - 22'd1;
      else if (!win && TRight)        angleNext = angle + 22'd1;
      else if (!win && TLeft)         angleNext = angle - 22'd1;
    end
  end

  // Control state: FSM, row index, heading, snapshot, bank select, overrun.
  always_ff @(posedge logicCLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      CordicIDX <= '0;
      angle     <= '0;
      angleOut  <= '0;
      bankSel   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= stateNext;
      CordicIDX <= idxNext;
      angle     <= angleNext;
      if (latchAngle) angleOut <= angle[21:9];
      if (toggleBank) bankSel <= ~bankSel;
      if (frameStart && (state != IDLE)) overrun <= 1'b1;
    end
  end

  // Row storage: capture into the back bank, registered read of the front bank.
  always_ff @(posedge logicCLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 57; r++) begin
          bank[b][r] <= '0;
        end
      end
      rowData <= '0;
    end else begin
      if (wrEn) bank[bankSel][wrRow] <= CordicDATA;
      if (rowAddr <= 6'd56) rowData <= bank[!bankSel][rowAddr];
      else                  rowData <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_rotation_sequencer.sv
// Bench for sprite_rotation_sequencer: drives whole frames through a bench-timed
// CORDIC model, keeps its own copy of both banks and scores overlay reads.
module tb_sprite_rotation_sequencer;

  logic        logicCLK = 1'b0;
  logic        RSTn;
  logic        frameStart;
  logic        TLeft;
  logic        TRight;
  logic        win;
  logic        CordicRST;
  logic [9:0]  CordicIDX;
  logic        CordicDONE;
  logic [56:0] CordicDATA;
  logic [12:0] angleOut;
  logic [5:0]  rowAddr;
  logic [56:0] rowData;
  logic        bankSel;
  logic        busy;
  logic        overrun;
  logic        angleLoad;
  logic [21:0] angleLoadVal;
  logic [21:0] angleDbg;
  logic [2:0]  stateDbg;

  // clock
  always #5 logicCLK = ~logicCLK;

  sprite_rotation_sequencer dut (
    .logicCLK     (logicCLK),
    .RSTn         (RSTn),
    .frameStart   (frameStart),
    .TLeft        (TLeft),
    .TRight       (TRight),
    .win          (win),
    .CordicRST    (CordicRST),
    .CordicIDX    (CordicIDX),
    .CordicDONE   (CordicDONE),
    .CordicDATA   (CordicDATA),
    .angleOut     (angleOut),
    .rowAddr      (rowAddr),
    .rowData      (rowData),
    .bankSel      (bankSel),
    .busy         (busy),
    .overrun      (overrun),
    .angleLoad    (angleLoad),
    .angleLoadVal (angleLoadVal),
    .angleDbg     (angleDbg),
    .stateDbg     (stateDbg)
  );

  int          checkCount = 0;
  int          errorCount = 0;
  logic [56:0] expQ [$];
  logic [56:0] mdl [2][57];
  logic        mdlBank;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [56:0] pat(input int fid, input int r);
    logic [56:0] v;
    v = {25'(fid), 16'hC3A5, 16'(r)};
    return v ^ (57'(r) << 30);
  endfunction

  task automatic tick();
    @(posedge logicCLK);
    #1;
  endtask

  task automatic clearModel();
    for (int r = 0; r < 57; r++) begin
      mdl[0][r] = '0;
      mdl[1][r] = '0;
    end
    mdlBank = 1'b0;
  endtask

  // scoreboard: push the expected front-bank row when the address is driven
  task automatic issueRead(input int addr);
    logic [56:0] e;
    rowAddr = 6'(addr);
    e = '0;
    if (addr <= 56) e = mdl[!mdlBank][addr];
    expQ.push_back(e);
  endtask

  task automatic collectRead(input string tag);
    if (expQ.size() != 0) checkVal(tag, 64'(rowData), 64'(expQ.pop_front()));
  endtask

  task automatic readRow(input int addr, input string tag);
    issueRead(addr);
    tick();
    collectRead(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_state"}, 64'(stateDbg), 64'd0);
    checkVal({tag, "_idx"}, 64'(CordicIDX), 64'd0);
    checkVal({tag, "_crst"}, 64'(CordicRST), 64'd0);
    checkVal({tag, "_angle"}, 64'(angleDbg), 64'd0);
    checkVal({tag, "_angleOut"}, 64'(angleOut), 64'd0);
    checkVal({tag, "_bank"}, 64'(bankSel), 64'd0);
    checkVal({tag, "_rowData"}, 64'(rowData), 64'd0);
    checkVal({tag, "_busy"}, 64'(busy), 64'd0);
    checkVal({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  // One frame: abortAt / resetAt are capture indices (-1 = never).
  task automatic runFrame(input int fid, input int abortAt, input int resetAt,
                          input bit ovr, input logic [21:0] ang);
    logic        oldBank;
    logic [21:0] capAngle;
    angleLoad    = 1'b1;
    angleLoadVal = ang;
    tick();
    angleLoad = 1'b0;
    checkVal("angle_load", 64'(angleDbg), 64'(ang));
    oldBank = mdlBank;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    checkVal("start_state", 64'(stateDbg), 64'd1);
    checkVal("cordic_rst_hi", 64'(CordicRST), 64'd1);
    checkVal("angle_out", 64'(angleOut), 64'(ang[21:9]));
    checkVal("busy_hi", 64'(busy), 64'd1);
    tick();
    checkVal("cordic_rst_lo", 64'(CordicRST), 64'd0);
    checkVal("wait_state", 64'(stateDbg), 64'd2);
    if (ovr) begin
      checkVal("overrun_pre", 64'(overrun), 64'd0);
      frameStart = 1'b1;
      tick();
      frameStart = 1'b0;
      checkVal("overrun_set", 64'(overrun), 64'd1);
      checkVal("overrun_no_rst", 64'(CordicRST), 64'd0);
      checkVal("overrun_state", 64'(stateDbg), 64'd2);
    end
    repeat (3) tick();
    checkVal("wait_hold", 64'(stateDbg), 64'd2);
    checkVal("wait_no_rst", 64'(CordicRST), 64'd0);
    CordicDONE = 1'b1;
    CordicDATA = 57'({$urandom(), $urandom()});
    tick();
    capAngle = angleDbg;
    TRight   = 1'b1;
    for (int k = 0; k <= 58; k++) begin
      checkVal("capture_state", 64'(stateDbg), 64'd3);
      checkVal("cordic_idx", 64'(CordicIDX), 64'(k));
      if (k == resetAt) begin
        RSTn = 1'b0;
        #1;
        checkAllZero("midcap_reset");
        clearModel();
        expQ.delete();
        TRight     = 1'b0;
        CordicDONE = 1'b0;
        RSTn       = 1'b1;
        return;
      end
      if (k == abortAt) begin
        CordicDONE = 1'b0;
        tick();
        checkVal("abort_state", 64'(stateDbg), 64'd0);
        checkVal("abort_idx", 64'(CordicIDX), 64'd0);
        checkVal("abort_bank", 64'(bankSel), 64'(oldBank));
        checkVal("abort_angle", 64'(angleDbg), 64'(capAngle));
        TRight = 1'b0;
        return;
      end
      if (k >= 2) begin
        CordicDATA = pat(fid, k - 2);
        mdl[mdlBank][k - 2] = CordicDATA;
      end else begin
        CordicDATA = 57'({$urandom(), $urandom()});
      end
      tick();
    end
    checkVal("swap_state", 64'(stateDbg), 64'd4);
    checkVal("angle_frozen", 64'(angleDbg), 64'(capAngle));
    checkVal("swap_bank_pre", 64'(bankSel), 64'(oldBank));
    TRight     = 1'b0;
    CordicDONE = 1'b0;
    issueRead(7);
    tick();
    collectRead("read_at_swap");
    mdlBank = !mdlBank;
    checkVal("swap_bank_post", 64'(bankSel), 64'(!oldBank));
    checkVal("idle_after_swap", 64'(stateDbg), 64'd0);
    checkVal("busy_lo", 64'(busy), 64'd0);
  endtask

  initial begin
    RSTn = 1'b0; frameStart = 1'b0; TLeft = 1'b0; TRight = 1'b0; win = 1'b0;
    CordicDONE = 1'b0; CordicDATA = '0; rowAddr = '0;
    angleLoad = 1'b0; angleLoadVal = '0;
    clearModel();
    repeat (2) tick();
    checkAllZero("reset");
    RSTn = 1'b1;
    repeat (4) tick();
    checkVal("idle_no_action", 64'(stateDbg), 64'd0);
    checkVal("idle_no_rst", 64'(CordicRST), 64'd0);
    readRow(5, "reset_row5");

    // nominal frame
    runFrame(1, -1, -1, 1'b0, 22'h0A5A00);
    readRow(5, "nom_row5");
    readRow(0, "nom_row0");
    readRow(56, "nom_row56");
    readRow(57, "nom_row57");
    readRow(63, "nom_row63");
    for (int i = 0; i < 8; i++) readRow($urandom_range(0, 63), "nom_rand");

    // abort mid-capture: front bank keeps frame 1
    runFrame(2, 30, -1, 1'b0, 22'h3F0200);
    readRow(5, "abort_row5");
    readRow(20, "abort_row20");

    // full frame after abort, then overrun frame
    runFrame(3, -1, -1, 1'b0, 22'h123456);
    for (int i = 0; i < 6; i++) readRow($urandom_range(0, 56), "f3_rand");
    runFrame(4, -1, -1, 1'b1, 22'h2ABCDE);
    checkVal("overrun_sticky", 64'(overrun), 64'd1);
    readRow(33, "f4_row33");

    // heading wrap and steering
    angleLoad = 1'b1; angleLoadVal = 22'h191FFF; tick(); angleLoad = 1'b0;
    TRight = 1'b1;
    tick(); checkVal("wrap_up_pi", 64'(angleDbg), 64'h192000);
    tick(); checkVal("wrap_up_neg", 64'(angleDbg), 64'h26E001);
    tick(); checkVal("wrap_up_next", 64'(angleDbg), 64'h26E002);
    TRight = 1'b0;
    angleLoad = 1'b1; angleLoadVal = 22'h26E001; tick(); angleLoad = 1'b0;
    TLeft = 1'b1;
    tick(); checkVal("wrap_dn_negpi", 64'(angleDbg), 64'h26E000);
    tick(); checkVal("wrap_dn_pi", 64'(angleDbg), 64'h191FFF);
    tick(); checkVal("wrap_dn_next", 64'(angleDbg), 64'h191FFE);
    TLeft = 1'b0;
    angleLoad = 1'b1; angleLoadVal = 22'h000000; tick(); angleLoad = 1'b0;
    TLeft = 1'b1;
    tick(); checkVal("left_from_zero", 64'(angleDbg), 64'h3FFFFF);
    TLeft = 1'b0;
    angleLoad = 1'b1; angleLoadVal = 22'h000100; tick(); angleLoad = 1'b0;
    win = 1'b1; TRight = 1'b1;
    repeat (100) tick();
    checkVal("win_freeze", 64'(angleDbg), 64'h000100);
    win = 1'b0; TLeft = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkVal("right_beats_left", 64'(angleDbg), 64'(22'h000100 + 22'(i)));
    end
    TLeft = 1'b0; TRight = 1'b0;

    // reset mid-capture, then a clean restart
    runFrame(5, -1, 40, 1'b0, 22'h155500);
    repeat (4) tick();
    checkVal("post_reset_idle", 64'(stateDbg), 64'd0);
    checkVal("post_reset_no_rst", 64'(CordicRST), 64'd0);
    readRow(12, "post_reset_row12");
    runFrame(6, -1, -1, 1'b0, 22'h0F0F00);
    readRow(5, "final_row5");
    readRow(56, "final_row56");
    checkVal("final_overrun", 64'(overrun), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
